// File: rtl/rcounter_commander.sv
// ---------------------------------------------------------------------------
// rcounter_commander
//   Countdown stopwatch controller driven by five debounced buttons. The user
//   edits a mm:ss.cc preset field by field (SET), starts/pauses the countdown
//   (RUN), and gets a timeout level once the value reaches zero (DONE).
//
// Ports
//   clk_core       in   core clock, rising edge
//   rst            in   asynchronous active-high reset
//   left_button    in   select next more-significant field
//   right_button   in   select next less-significant field
//   up_button      in   increment selected field
//   down_button    in   decrement selected field
//   center_button  in   start / pause / acknowledge
//   min_o          out  BCD minutes   00-59
//   sec_o          out  BCD seconds   00-59
//   ms_10_o        out  BCD hundredths 00-99
//   time_out_o     out  high while in DONE
//   target         out  selected field: 0 = ms_10, 1 = sec, 2 = min
//   state_dbg      out  FSM state for observation: 0 = SET, 1 = RUN, 2 = DONE
//
// Every output comes straight from a register; buttons only reach outputs
// through the clocked edge detector.
// ---------------------------------------------------------------------------
module rcounter_commander #(
   parameter int         CLK_DIV   = 1_000_000,
   parameter logic [7:0] INIT_MIN  = 8'h01,
   parameter logic [7:0] INIT_SEC  = 8'h00,
   parameter logic [7:0] INIT_MS10 = 8'h00
) (
   input  logic       clk_core,
   input  logic       rst,
   input  logic       left_button,
   input  logic       right_button,
   input  logic       up_button,
   input  logic       down_button,
   input  logic       center_button,
   output logic [7:0] min_o,
   output logic [7:0] sec_o,
   output logic [7:0] ms_10_o,
   output logic       time_out_o,
   output logic [1:0] target,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      ST_SET  = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int          TW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);

   state_t      state;
   logic [7:0]  min_r;
   logic [7:0]  sec_r;
   logic [7:0]  ms_r;
   logic [1:0]  target_r;
   logic        time_out_r;
   logic [TW-1:0] tick;
   logic [4:0]  btn_q;

   // Bit order: 0 center, 1 left, 2 right, 3 up, 4 down (priority low->high index)
   logic [4:0]  btn;
   logic [4:0]  rise;
   logic        is_zero;
   logic        is_last;

   assign btn     = {down_button, up_button, right_button, left_button, center_button};
   assign rise    = btn & ~btn_q;
   assign is_zero = (min_r == 8'h00) && (sec_r == 8'h00) && (ms_r == 8'h00);
   // The decrement taking 00:00.01 to zero is the one that enters DONE.
   assign is_last = (min_r == 8'h00) && (sec_r == 8'h00) && (ms_r == 8'h01);

   // BCD +1 with wrap from max_v to 00.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
      if (v == max_v)         return 8'h00;
      else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      else                     return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // BCD -1 with wrap from 00 to max_v.
   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
      if (v == 8'h00)          return max_v;
      else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
      else                     return {v[7:4], v[3:0] - 4'd1};
   endfunction

   always_ff @(posedge clk_core or posedge rst) begin
      if (rst) begin
         state      <= ST_SET;
         min_r      <= INIT_MIN;
         sec_r      <= INIT_SEC;
         ms_r       <= INIT_MS10;
         target_r   <= 2'd1;
         time_out_r <= 1'b0;
         tick       <= '0;
         btn_q      <= '0;
      end else begin
         btn_q <= btn;
         case (state)
            ST_SET: begin
               if (rise[0]) begin
                  if (!is_zero) begin
                     state <= ST_RUN;
                     tick  <= '0;
                  end
               end else if (rise[1]) begin
                  target_r <= (target_r == 2'd2) ? 2'd0 : target_r + 2'd1;
               end else if (rise[2]) begin
                  target_r <= (target_r == 2'd0) ? 2'd2 : target_r - 2'd1;
               end else if (rise[3]) begin
                  case (target_r)
                     2'd0:    ms_r  <= bcd_inc(ms_r, 8'h99);
                     2'd1:    sec_r <= bcd_inc(sec_r, 8'h59);
                     default: min_r <= bcd_inc(min_r, 8'h59);
                  endcase
               end else if (rise[4]) begin
                  case (target_r)
                     2'd0:    ms_r  <= bcd_dec(ms_r, 8'h99);
                     2'd1:    sec_r <= bcd_dec(sec_r, 8'h59);
                     default: min_r <= bcd_dec(min_r, 8'h59);
                  endcase
               end
            end

            ST_RUN: begin
               // Pause wins over a coinciding tick; value and phase are held.
               if (rise[0]) begin
                  state <= ST_SET;
               end else if (tick == TICK_LAST) begin
                  tick <= '0;
                  if (ms_r != 8'h00) begin
                     ms_r <= bcd_dec(ms_r, 8'h99);
                  end else begin
                     ms_r <= 8'h99;
                     if (sec_r != 8'h00) begin
                        sec_r <= bcd_dec(sec_r, 8'h59);
                     end else begin
                        // Nonzero value with ms and sec at zero: min > 0 here.
                        sec_r <= 8'h59;
                        min_r <= bcd_dec(min_r, 8'h59);
                     end
                  end
                  if (is_last) begin
                     state      <= ST_DONE;
                     time_out_r <= 1'b1;
                  end
               end else begin
                  tick <= tick + TW'(1);
               end
            end

            ST_DONE: begin
               // Any press only acknowledges; it performs no edit.
               if (|rise) begin
                  state      <= ST_SET;
                  time_out_r <= 1'b0;
               end
            end

            default: state <= ST_SET;
         endcase
      end
   end

   assign min_o      = min_r;
   assign sec_o      = sec_r;
   assign ms_10_o    = ms_r;
   assign time_out_o = time_out_r;
   assign target     = target_r;
   assign state_dbg  = state;

endmodule

// File: tb/tb_rcounter_commander.sv
// ---------------------------------------------------------------------------
// tb_rcounter_commander
//   Bench for rcounter_commander with CLK_DIV = 10. A centisecond-based
//   reference model predicts every observed cycle; predictions go to exp_q
//   when a cycle is driven and are popped and compared 1 time unit after
//   the following rising edge.
// ---------------------------------------------------------------------------
module tb_rcounter_commander;

   localparam int CLK_DIV = 10;
   localparam int W       = 29;

   // Button vector bit order
   localparam logic [4:0] B_C = 5'b00001;
   localparam logic [4:0] B_L = 5'b00010;
   localparam logic [4:0] B_R = 5'b00100;
   localparam logic [4:0] B_U = 5'b01000;
   localparam logic [4:0] B_D = 5'b10000;
   localparam logic [4:0] B_0 = 5'b00000;

   // ---------------- clock / reset ----------------
   logic clk_core = 1'b0;
   logic rst      = 1'b1;
   always #5 clk_core = ~clk_core;

   logic       left_button, right_button, up_button, down_button, center_button;
   logic [7:0] min_o, sec_o, ms_10_o;
   logic       time_out_o;
   logic [1:0] target, state_dbg;

   rcounter_commander #(
      .CLK_DIV  (CLK_DIV),
      .INIT_MIN (8'h01),
      .INIT_SEC (8'h00),
      .INIT_MS10(8'h00)
   ) dut (
      .clk_core     (clk_core),
      .rst          (rst),
      .left_button  (left_button),
      .right_button (right_button),
      .up_button    (up_button),
      .down_button  (down_button),
      .center_button(center_button),
      .min_o        (min_o),
      .sec_o        (sec_o),
      .ms_10_o      (ms_10_o),
      .time_out_o   (time_out_o),
      .target       (target),
      .state_dbg    (state_dbg)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got min=%h sec=%h ms=%h tgt=%0d to=%b st=%0d, expected min=%h sec=%h ms=%h tgt=%0d to=%b st=%0d",
                  tag, obs[28:21], obs[20:13], obs[12:5], obs[4:3], obs[2], obs[1:0],
                  exp[28:21], exp[20:13], exp[12:5], exp[4:3], exp[2], exp[1:0]);
      end
   endtask

   // ---------------- reference model ----------------
   // fld[0] = hundredths, fld[1] = seconds, fld[2] = minutes (binary ints)
   int         fld[3];
   int         m_state;   // 0 SET, 1 RUN, 2 DONE
   int         m_target;
   int         m_tick;
   logic       m_to;
   logic [4:0] m_prev;

   function automatic logic [7:0] to_bcd(input int n);
      logic [3:0] hi, lo;
      hi = 4'(n / 10);
      lo = 4'(n % 10);
      return {hi, lo};
   endfunction

   function automatic int lim(input int i);
      return (i == 0) ? 100 : 60;
   endfunction

   function automatic logic [W-1:0] model_word();
      return {to_bcd(fld[2]), to_bcd(fld[1]), to_bcd(fld[0]),
              2'(m_target), m_to, 2'(m_state)};
   endfunction

   function automatic logic [W-1:0] dut_word();
      return {min_o, sec_o, ms_10_o, target, time_out_o, state_dbg};
   endfunction

   task automatic model_reset();
      fld[2] = 1; fld[1] = 0; fld[0] = 0;
      m_state = 0; m_target = 1; m_tick = 0; m_to = 1'b0; m_prev = '0;
   endtask

   // Predicts the effect of the next rising edge with buttons b applied.
   task automatic model_edge(input logic [4:0] b);
      logic [4:0] r;
      int total;
      r = b & ~m_prev;
      m_prev = b;
      total = fld[2] * 6000 + fld[1] * 100 + fld[0];
      case (m_state)
         0: begin
            if (r[0]) begin
               if (total != 0) begin m_state = 1; m_tick = 0; end
            end else if (r[1]) m_target = (m_target + 1) % 3;
            else if (r[2])     m_target = (m_target + 2) % 3;
            else if (r[3])     fld[m_target] = (fld[m_target] + 1) % lim(m_target);
            else if (r[4])     fld[m_target] = (fld[m_target] + lim(m_target) - 1) % lim(m_target);
         end
         1: begin
            if (r[0]) m_state = 0;
            else if (m_tick == CLK_DIV - 1) begin
               m_tick = 0;
               total  = total - 1;
               fld[2] = total / 6000;
               fld[1] = (total / 100) % 60;
               fld[0] = total % 100;
               if (total == 0) begin m_state = 2; m_to = 1'b1; end
            end else m_tick++;
         end
         default: begin
            if (r != 0) begin m_state = 0; m_to = 1'b0; end
         end
      endcase
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [4:0] b);
      center_button = b[0];
      left_button   = b[1];
      right_button  = b[2];
      up_button     = b[3];
      down_button   = b[4];
   endtask

   // One clock: drive b, predict, then compare after the edge if chk.
   task automatic step(input logic [4:0] b, input bit chk, input string tag);
      @(negedge clk_core);
      drive(b);
      model_edge(b);
      if (chk) exp_q.push_back(model_word());
      @(posedge clk_core);
      #1;
      if (chk) check(tag, dut_word(), exp_q.pop_front());
   endtask

   // Press-and-release, checking the cycle the press takes effect.
   task automatic press(input logic [4:0] b, input string tag);
      step(b, 1'b1, tag);
      step(B_0, 1'b0, "");
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(B_0, (i == n - 1), tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk_core);
      rst = 1'b1;
      drive(B_0);
      model_reset();
      #1;
      check(tag, dut_word(), model_word());
      @(negedge clk_core);
      rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      drive(B_0);
      model_reset();
      repeat (2) @(posedge clk_core);
      do_reset("reset_vals");

      // Start from 01:00.00; first decrement after CLK_DIV edges
      press(B_C, "start");
      idle(CLK_DIV - 2, "run_first_tick");   // press() already spent 2 cycles

      // Field editing
      do_reset("reset2");
      press(B_L, "left_to_min");
      press(B_U, "min_up");
      press(B_R, "right1");
      press(B_R, "right_to_ms");
      press(B_D, "ms_down_wrap");

      // Build 00:00.02 then run to DONE
      do_reset("reset3");
      press(B_L, "sel_min");
      press(B_D, "min_to_00");
      press(B_R, "sel_sec");
      press(B_R, "sel_ms");
      press(B_U, "ms_01");
      press(B_U, "ms_02");
      step(B_C, 1'b1, "start_002");
      for (int i = 0; i < 2 * CLK_DIV; i++) step(B_0, (i >= 2 * CLK_DIV - 2), "countdown_done");
      idle(3, "done_hold");
      press(B_U, "done_ack");

      // Wraps in SET (now 00:00.00, target 0)
      press(B_C, "start_at_zero");
      press(B_R, "wrap_tgt_0_to_2");
      press(B_D, "min_00_down");
      press(B_L, "wrap_tgt_2_to_0");
      press(B_R, "tgt_2");
      press(B_R, "tgt_1");
      press(B_D, "sec_00_down");
      press(B_U, "sec_59_up");

      // Ignored buttons in RUN, pause and resume
      do_reset("reset4");
      press(B_C, "start2");
      idle(13, "run_mid");
      press(B_R, "run_right_ign");
      press(B_U, "run_up_ign");
      press(B_D, "run_down_ign");
      press(B_C, "pause");
      idle(25, "paused_hold");
      press(B_C, "resume");
      idle(CLK_DIV, "resumed");

      // Hold center in SET: single start only
      do_reset("reset5");
      for (int i = 0; i < 5; i++) step(B_C, 1'b1, "hold_center");
      idle(2, "hold_release");

      // Reset in the middle of RUN (asynchronous)
      idle(7, "pre_rst");
      do_reset("rst_mid_run");
      idle(1, "post_rst");

      // Random button traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [4:0] b;
         b = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : B_0;
         step(b, 1'b1, "random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
